// File: rtl/namuru_chan_bus_if.sv
// -----------------------------------------------------------------------------
// namuru_chan_bus_if
// WISHBONE classic single-access bus bundle between an SoC master and the
// namuru correlator-array front-end.
//   wb_adr_i  : byte address (bits [1:0] unused by the slave)
//   wb_dat_i  : write data
//   wb_dat_o  : read data, non-zero only while wb_ack_o is high
//   wb_sel_i  : byte enables
//   wb_stb_i  : strobe
//   wb_cyc_i  : cycle (dropping it abandons an outstanding channel access)
//   wb_we_i   : write enable
//   wb_ack_o  : single-cycle acknowledge
// Modports: master drives the request side, slave drives dat_o/ack_o.
// -----------------------------------------------------------------------------
interface namuru_chan_bus_if;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_i;
   logic        wb_stb_i;
   logic        wb_cyc_i;
   logic        wb_we_i;
   logic        wb_ack_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
      output wb_dat_o, wb_ack_o
   );
endinterface

// File: rtl/namuru_chan_bus.sv
// -----------------------------------------------------------------------------
// namuru_chan_bus
// WISHBONE slave front-end for an array of GPS correlator channels. The word
// address is split into a region (channel number, global window or unmapped)
// and a register index. Channel accesses are forwarded over a one-hot strobe
// and guarded by an ack timeout; global accesses hit STATUS/MASK/ERR/ID.
// Accumulation-dump pulses are latched in STATUS and masked into irq_o.
//
// Ports:
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   wb                 : WISHBONE slave bundle (namuru_chan_bus_if.slave)
//   ch_stb_o           : one-hot channel strobe, held for the whole wait
//   ch_we_o/ch_adr_o/ch_sel_o/ch_dat_o : channel request, held with ch_stb_o
//   ch_dat_i           : packed channel read data, channel c at [32c+31:32c]
//   ch_ack_i           : channel acknowledges (only the selected one counts)
//   accum_i            : per-channel accumulation-dump pulses
//   irq_o              : registered |(STATUS & MASK)
// -----------------------------------------------------------------------------
module namuru_chan_bus #(
   parameter int NCHAN     = 12,
   parameter int CHAN_AW   = 4,
   parameter int TO_CYCLES = 15
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   namuru_chan_bus_if.slave      wb,
   output logic [NCHAN-1:0]      ch_stb_o,
   output logic                  ch_we_o,
   output logic [CHAN_AW-1:0]    ch_adr_o,
   output logic [3:0]            ch_sel_o,
   output logic [31:0]           ch_dat_o,
   input  logic [32*NCHAN-1:0]   ch_dat_i,
   input  logic [NCHAN-1:0]      ch_ack_i,
   input  logic [NCHAN-1:0]      accum_i,
   output logic                  irq_o
);

   // Region field is wide enough to name every channel plus the global window.
   localparam int CIW = $clog2(NCHAN + 1);
   localparam int AHI = CHAN_AW + CIW + 1;
   localparam logic [CIW-1:0]     GLOB_C     = CIW'(NCHAN);
   localparam logic [7:0]         TO_LOAD    = 8'(TO_CYCLES);
   localparam logic [CHAN_AW-1:0] REG_STATUS = CHAN_AW'(0);
   localparam logic [CHAN_AW-1:0] REG_MASK   = CHAN_AW'(1);
   localparam logic [CHAN_AW-1:0] REG_ERR    = CHAN_AW'(2);
   localparam logic [CHAN_AW-1:0] REG_ID     = CHAN_AW'(3);
   localparam logic [31:0]        ID_VAL     = {16'h4E4D, 8'd0, 8'(NCHAN)};

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CH_WAIT = 2'd1,
      S_ACK     = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_ack;
   logic [31:0]           r_dat;
   logic [NCHAN-1:0]      r_ch_stb;
   logic                  r_ch_we;
   logic [CHAN_AW-1:0]    r_ch_adr;
   logic [3:0]            r_ch_sel;
   logic [31:0]           r_ch_dat;
   logic [CIW-1:0]        r_ch_idx;
   logic [7:0]            r_cnt;
   logic [NCHAN-1:0]      r_status;
   logic [NCHAN-1:0]      r_mask;
   logic [NCHAN-1:0]      r_err;
   logic                  r_irq;

   logic [CHAN_AW+CIW-1:0] w_word;
   logic [CIW-1:0]         w_c;
   logic [CHAN_AW-1:0]     w_r;
   logic                   w_req;
   logic                   w_is_chan;
   logic                   w_is_glob;
   logic [NCHAN-1:0]       w_onehot;
   logic [31:0]            w_ch_rdata;
   logic                   w_ch_ack;
   logic [31:0]            w_glob_rdata;
   logic [31:0]            w_bytemask;
   logic [31:0]            w_mask_merged;
   logic                   w_ack_nxt;
   logic [31:0]            w_dat_nxt;
   logic [NCHAN-1:0]       w_ch_stb_nxt;
   logic                   w_load_ch;
   logic [7:0]             w_cnt_nxt;
   logic [NCHAN-1:0]       w_err_set;
   logic [NCHAN-1:0]       w_status_clr;
   logic [NCHAN-1:0]       w_err_clr;
   logic                   w_mask_wr;
   logic                   w_unused;

   assign w_word    = wb.wb_adr_i[AHI:2];
   assign w_c       = w_word[CHAN_AW+CIW-1:CHAN_AW];
   assign w_r       = w_word[CHAN_AW-1:0];
   assign w_req     = wb.wb_cyc_i & wb.wb_stb_i;
   assign w_is_chan = (w_c < GLOB_C);
   assign w_is_glob = (w_c == GLOB_C);
   // Upper address bits and the byte offset are deliberately ignored.
   assign w_unused  = ^{wb.wb_adr_i[31:AHI+1], wb.wb_adr_i[1:0]};

   assign w_bytemask    = {{8{wb.wb_sel_i[3]}}, {8{wb.wb_sel_i[2]}},
                           {8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
   assign w_mask_merged = (32'(r_mask) & ~w_bytemask) | (wb.wb_dat_i & w_bytemask);

   assign wb.wb_ack_o = r_ack;
   assign wb.wb_dat_o = r_dat;
   assign ch_stb_o    = r_ch_stb;
   assign ch_we_o     = r_ch_we;
   assign ch_adr_o    = r_ch_adr;
   assign ch_sel_o    = r_ch_sel;
   assign ch_dat_o    = r_ch_dat;
   assign irq_o       = r_irq;

   // Channel select decode and AND-OR mux of the latched channel's data/ack.
   always_comb begin
      w_onehot   = {NCHAN{1'b0}};
      w_ch_rdata = 32'd0;
      w_ch_ack   = 1'b0;
      for (int i = 0; i < NCHAN; i++) begin
         w_onehot[i] = (w_c == CIW'(i));
         w_ch_rdata  = w_ch_rdata | (ch_dat_i[32*i +: 32] & {32{r_ch_idx == CIW'(i)}});
         w_ch_ack    = w_ch_ack | (ch_ack_i[i] & (r_ch_idx == CIW'(i)));
      end
   end

   // Global window read mux; unmapped regions read as zero.
   always_comb begin
      w_glob_rdata = 32'd0;
      if (w_is_glob) begin
         case (w_r)
            REG_STATUS: w_glob_rdata = 32'(r_status);
            REG_MASK:   w_glob_rdata = 32'(r_mask);
            REG_ERR:    w_glob_rdata = 32'(r_err);
            REG_ID:     w_glob_rdata = ID_VAL;
            default:    w_glob_rdata = 32'd0;
         endcase
      end else begin
         w_glob_rdata = 32'd0;
      end
   end

   // Next-state logic and next values of the bus/channel registers.
   always_comb begin
      w_state_nxt  = r_state;
      w_ack_nxt    = 1'b0;
      w_dat_nxt    = 32'd0;
      w_ch_stb_nxt = r_ch_stb;
      w_load_ch    = 1'b0;
      w_cnt_nxt    = r_cnt;
      w_err_set    = {NCHAN{1'b0}};
      w_status_clr = {NCHAN{1'b0}};
      w_err_clr    = {NCHAN{1'b0}};
      w_mask_wr    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req && w_is_chan) begin
               w_state_nxt  = S_CH_WAIT;
               w_ch_stb_nxt = w_onehot;
               w_load_ch    = 1'b1;
               w_cnt_nxt    = TO_LOAD;
            end else if (w_req) begin
               w_state_nxt = S_ACK;
               w_ack_nxt   = 1'b1;
               if (wb.wb_we_i && w_is_glob) begin
                  case (w_r)
                     REG_STATUS: w_status_clr = wb.wb_dat_i[NCHAN-1:0];
                     REG_MASK:   w_mask_wr    = 1'b1;
                     REG_ERR:    w_err_clr    = wb.wb_dat_i[NCHAN-1:0];
                     default:    w_mask_wr    = 1'b0;
                  endcase
               end else if (!wb.wb_we_i) begin
                  w_dat_nxt = w_glob_rdata;
               end else begin
                  // Write to an unmapped region: acknowledged and dropped.
                  w_dat_nxt = 32'd0;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_CH_WAIT: begin
            // Abort wins over a simultaneous ack or timeout: no ack is owed.
            if (!wb.wb_cyc_i) begin
               w_state_nxt  = S_IDLE;
               w_ch_stb_nxt = {NCHAN{1'b0}};
            end else if (w_ch_ack) begin
               w_state_nxt  = S_ACK;
               w_ack_nxt    = 1'b1;
               w_dat_nxt    = r_ch_we ? 32'd0 : w_ch_rdata;
               w_ch_stb_nxt = {NCHAN{1'b0}};
            end else if (r_cnt == 8'd0) begin
               w_state_nxt  = S_ACK;
               w_ack_nxt    = 1'b1;
               w_err_set    = r_ch_stb;
               w_ch_stb_nxt = {NCHAN{1'b0}};
            end else begin
               w_cnt_nxt = r_cnt - 8'd1;
            end
         end
         S_ACK: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt  = S_IDLE;
            w_ch_stb_nxt = {NCHAN{1'b0}};
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Bus response, channel request, global registers and interrupt.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         r_ack    <= 1'b0;
         r_dat    <= 32'd0;
         r_ch_stb <= {NCHAN{1'b0}};
         r_ch_we  <= 1'b0;
         r_ch_adr <= {CHAN_AW{1'b0}};
         r_ch_sel <= 4'd0;
         r_ch_dat <= 32'd0;
         r_ch_idx <= {CIW{1'b0}};
         r_cnt    <= 8'd0;
         r_status <= {NCHAN{1'b0}};
         r_mask   <= {NCHAN{1'b0}};
         r_err    <= {NCHAN{1'b0}};
         r_irq    <= 1'b0;
      end else begin
         r_ack    <= w_ack_nxt;
         r_dat    <= w_dat_nxt;
         r_ch_stb <= w_ch_stb_nxt;
         r_cnt    <= w_cnt_nxt;
         if (w_load_ch) begin
            r_ch_we  <= wb.wb_we_i;
            r_ch_adr <= w_r;
            r_ch_sel <= wb.wb_sel_i;
            r_ch_dat <= wb.wb_dat_i;
            r_ch_idx <= w_c;
         end
         // Set has priority over a same-cycle write-1-to-clear.
         r_status <= (r_status & ~w_status_clr) | accum_i;
         r_err    <= (r_err & ~w_err_clr) | w_err_set;
         if (w_mask_wr) begin
            r_mask <= w_mask_merged[NCHAN-1:0];
         end
         r_irq    <= |(r_status & r_mask);
      end
   end

endmodule

// File: doc/namuru_chan_bus.md
# namuru_chan_bus

Single-clock WISHBONE slave front-end for a multi-channel GPS correlator array. It decodes the bus address into one of NCHAN correlator channel register windows or a global control window. It runs the channel handshake with timeout protection and latches per-channel accumulation events into a maskable interrupt. It sits between the SoC bus and the correlator channels, all in the `sys_clk` domain.

## Interface
Parameters:
- NCHAN, 12: number of correlator channels; legal 1..32.
- CHAN_AW, 4: word-address bits per channel window (2^CHAN_AW registers per channel).
- TO_CYCLES, 15: channel ack timeout in cycles; legal 1..255.

Ports (clock and reset first):
- sys_clk  in  1  single clock for all logic.
- sys_rst_n  in  1  reset, synchronous and active-low.
- wb_adr_i  in  32  byte address; bits [1:0] ignored.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data; valid while wb_ack_o is high, otherwise 0.
- wb_sel_i  in  4  byte enables.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle.
- wb_we_i  in  1  write enable.
- wb_ack_o  out  1  single-cycle acknowledge.
- ch_stb_o  out  NCHAN  one-hot channel strobe.
- ch_we_o  out  1  channel write enable.
- ch_adr_o  out  CHAN_AW  channel register index.
- ch_sel_o  out  4  channel byte enables.
- ch_dat_o  out  32  channel write data.
- ch_dat_i  in  32*NCHAN  channel read data; channel c occupies [32c+31:32c].
- ch_ack_i  in  NCHAN  channel acknowledge.
- accum_i  in  NCHAN  per-channel accumulation-dump pulses.
- irq_o  out  1  interrupt, registered.

## Operation
- Address decode: w = wb_adr_i[CHAN_AW+CIW+1:2], where CIW = ceil(log2(NCHAN+1)). Region c = w[CHAN_AW+CIW-1:CHAN_AW]; register r = w[CHAN_AW-1:0]. Higher address bits are ignored.
- c < NCHAN: channel access. c == NCHAN: global window. c > NCHAN: unmapped; acked, reads return 0, writes are dropped.
- Global registers:
  - r=0 STATUS: accum flags; RO, write-1-to-clear.
  - r=1 MASK: RW; honours wb_sel_i.
  - r=2 ERR: per-channel sticky timeout flags; write-1-to-clear.
  - r=3 ID: {16'h4E4D, 8'd0, 8'(NCHAN)}, read-only.
  - Other r: read 0, writes ignored.
  - Bits ≥ NCHAN in STATUS, MASK and ERR read 0.
- FSM states: IDLE, CH_WAIT, ACK.
  - IDLE, with cyc&stb and a global/unmapped address: perform the register access, then go to ACK.
  - IDLE, with cyc&stb and a channel address: drive ch_stb_o[c]=1 plus ch_we/adr/sel/dat, load the timeout counter with TO_CYCLES, go to CH_WAIT.
  - CH_WAIT, ch_ack_i[c]=1: capture ch_dat_i[c] (reads), drop ch_stb_o, go to ACK.
  - CH_WAIT, counter reaches 0: set ERR[c], read data = 0, drop ch_stb_o, go to ACK.
  - CH_WAIT, wb_cyc_i low (abort): drop ch_stb_o, go to IDLE, no ack.
  - ACK: wb_ack_o=1 for exactly one cycle, then go to IDLE.
- Channel outputs are held stable for the whole CH_WAIT. ch_ack_i from non-selected channels is ignored.
- STATUS[c] sets on accum_i[c]=1. If a set and a W1C of the same bit happen in the same cycle, the set wins.
- irq_o <= |(STATUS & MASK), updated every cycle.

## Timing
- Reset (sys_rst_n low at a clock edge) forces:
  - FSM to IDLE.
  - wb_ack_o, wb_dat_o, ch_stb_o, ch_we_o, ch_adr_o, ch_sel_o, ch_dat_o all to 0.
  - STATUS, MASK, ERR and irq_o to 0.
- Reset mid-transfer abandons the transfer with no ack.
- Global access: stb sampled at edge N; ack high during cycle N+1.
- Channel access: ch_stb_o high from cycle N+1. If ch_ack_i is sampled at edge M, wb_ack_o is high during cycle M+1.
- Minimum channel latency is 2 cycles from stb to ack.
- Timeout: with no ch_ack_i, wb_ack_o arrives TO_CYCLES+2 cycles after stb is sampled.
- After ACK, one IDLE cycle elapses before the next request is accepted. Back-to-back transfers are therefore spaced by at least 1 idle cycle.
- irq_o lags an accum_i pulse by 2 cycles: one for STATUS, one for the irq register.

## Test plan
- Reset values: hold sys_rst_n=0 for 3 cycles, then read ID → all outputs are 0 during reset, and the ID read returns 0x4E4D000C (NCHAN=12).
- Channel read: read channel 5, reg 3; the channel acks 4 cycles after ch_stb_o with 0xCAFEF00D → ch_stb_o=0x020, ch_adr_o=3, wb_dat_o=0xCAFEF00D, wb_ack_o one cycle after ch_ack_i.
- Timeout: write channel 7 with no ch_ack_i → wb_ack_o after 17 cycles; ERR reads 0x080; writing 0x080 to ERR clears it to 0.
- Interrupt: MASK=0x004, pulse accum_i[2] → irq_o=1 two cycles later. Pulse accum_i[2] in the same cycle as a STATUS W1C of 0x004 → STATUS stays 0x004.
- Abort: drop wb_cyc_i in the 2nd CH_WAIT cycle → ch_stb_o=0 next cycle, no wb_ack_o, next global read acks in 1 cycle.
- Byte enables and unmapped region: write MASK 0xFFFFFFFF with sel=0001 → MASK reads 0x000000FF. Read c=14 → ack with 0.
